// File: rtl/speck_msg_loader_pkg.sv
// Shared widths, defaults and loader state encoding for the SPECK message loader.
// S_LEN exists only when SPECK_LOADER_LEN_EN is defined.
package speck_msg_loader_pkg;

    localparam int unsigned WORD_W       = 64;
    localparam int unsigned CNT_W        = 58;
    localparam int unsigned CORE_LAT_DEF = 14;

    localparam logic [WORD_W-1:0] IV_DEF       = 64'h0;
    localparam logic [WORD_W-1:0] KEY_DEF      = 64'h0F0E0D0C0B0A0908;
    localparam logic [WORD_W-1:0] PAD_WORD_DEF = 64'h8000000000000000;

    typedef enum logic [2:0] {
        S_FX   = 3'd0,
        S_FY   = 3'd1,
        S_RUN  = 3'd2,
        S_PAD  = 3'd3,
`ifdef SPECK_LOADER_LEN_EN
        S_LEN  = 3'd4,
`endif
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/speck_msg_loader_if.sv
// Signal bundle between the message loader, its word stream source and the SPECK core.
// master = loader side, slave = environment (stream source, core, digest sink).
interface speck_msg_loader_if;
    import speck_msg_loader_pkg::*;

    logic [WORD_W-1:0] msg_data;
    logic              msg_valid;
    logic              msg_last;
    logic              msg_ready;
    logic [WORD_W-1:0] core_x;
    logic [WORD_W-1:0] core_y;
    logic [WORD_W-1:0] core_k;
    logic [WORD_W-1:0] core_h;
    logic              core_ld;
    logic              core_ld1;
    logic              core_cnt_rst;
    logic [WORD_W-1:0] core_hout;
    logic [WORD_W-1:0] digest;
    logic              digest_valid;
    logic              busy;

    modport master (
        input  msg_data, msg_valid, msg_last, core_hout,
        output msg_ready, core_x, core_y, core_k, core_h, core_ld, core_ld1,
               core_cnt_rst, digest, digest_valid, busy
    );

    modport slave (
        output msg_data, msg_valid, msg_last, core_hout,
        input  msg_ready, core_x, core_y, core_k, core_h, core_ld, core_ld1,
               core_cnt_rst, digest, digest_valid, busy
    );

endinterface

// File: rtl/speck_msg_loader_run_timer.sv
// Loadable saturating down counter timing the core latency; zero_o flags expiry.
module speck_msg_loader_run_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/speck_msg_loader.sv
// Packs 64-bit message words into {X,Y} blocks for the SPECK core, pads, chains H, emits digest.
// Length strengthening block (S_LEN, len_bits in core_y) enabled by defining SPECK_LOADER_LEN_EN.
module speck_msg_loader
    import speck_msg_loader_pkg::*;
#(
    parameter int unsigned       CORE_LAT = CORE_LAT_DEF,
    parameter logic [WORD_W-1:0] IV       = IV_DEF,
    parameter logic [WORD_W-1:0] KEY      = KEY_DEF,
    parameter logic [WORD_W-1:0] PAD_WORD = PAD_WORD_DEF
) (
    input logic                clk,
    input logic                reset,
    speck_msg_loader_if.master bus
);

    localparam int unsigned TW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] x_q, x_d, y_q, y_d, h_q, h_d, digest_q, digest_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic              ld_q, ld_d, ld1_q, dv_q, dv_d, busy_q, busy_d;
    logic              last_q, last_d, pad_q, pad_d;
    logic              ready, run_zero;
`ifdef SPECK_LOADER_LEN_EN
    logic              len_q, len_d;
    logic [WORD_W-1:0] len_bits;

    assign len_bits = {wc_q, 6'b0};
`endif

    // Timer is loaded during the core_ld cycle, so zero is reached CORE_LAT cycles after the pulse.
    speck_msg_loader_run_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ld_q),
        .value_i (TW'(CORE_LAT - 1)),
        .zero_o  (run_zero)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        h_d      = h_q;
        digest_d = digest_q;
        wc_d     = wc_q;
        ld_d     = 1'b0;
        dv_d     = 1'b0;
        busy_d   = busy_q;
        last_d   = last_q;
        pad_d    = pad_q;
        ready    = 1'b0;
`ifdef SPECK_LOADER_LEN_EN
        len_d    = len_q;
`endif
        case (state_q)
            S_FX: begin
                ready = 1'b1;
                if (bus.msg_valid) begin
                    x_d    = bus.msg_data;
                    wc_d   = wc_q + 1'b1;
                    busy_d = 1'b1;
                    if (bus.msg_last) begin
                        y_d     = PAD_WORD;
                        last_d  = 1'b1;
                        ld_d    = 1'b1;
                        state_d = S_RUN;
`ifdef SPECK_LOADER_LEN_EN
                        len_d   = 1'b1;
`endif
                    end else begin
                        state_d = S_FY;
                    end
                end
            end
            S_FY: begin
                ready = 1'b1;
                if (bus.msg_valid) begin
                    y_d     = bus.msg_data;
                    wc_d    = wc_q + 1'b1;
                    busy_d  = 1'b1;
                    ld_d    = 1'b1;
                    state_d = S_RUN;
                    if (bus.msg_last) begin
                        last_d = 1'b1;
                        pad_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!ld_q && run_zero) begin
                    h_d = bus.core_hout;
                    if (!last_q) begin
                        state_d = S_FX;
                    end else if (pad_q) begin
                        pad_d   = 1'b0;
                        state_d = S_PAD;
`ifdef SPECK_LOADER_LEN_EN
                    end else if (len_q) begin
                        len_d   = 1'b0;
                        state_d = S_LEN;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAD: begin
                x_d     = PAD_WORD;
`ifdef SPECK_LOADER_LEN_EN
                y_d     = len_bits;
`else
                y_d     = '0;
`endif
                ld_d    = 1'b1;
                state_d = S_RUN;
            end
`ifdef SPECK_LOADER_LEN_EN
            S_LEN: begin
                x_d     = '0;
                y_d     = len_bits;
                ld_d    = 1'b1;
                state_d = S_RUN;
            end
`endif
            S_DONE: begin
                digest_d = h_q;
                dv_d     = 1'b1;
                busy_d   = 1'b0;
                h_d      = IV;
                wc_d     = '0;
                last_d   = 1'b0;
                pad_d    = 1'b0;
                state_d  = S_FX;
            end
            default: state_d = S_FX;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FX;
            x_q      <= '0;
            y_q      <= '0;
            h_q      <= IV;
            digest_q <= '0;
            wc_q     <= '0;
            ld_q     <= 1'b0;
            ld1_q    <= 1'b0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b0;
            pad_q    <= 1'b0;
`ifdef SPECK_LOADER_LEN_EN
            len_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            h_q      <= h_d;
            digest_q <= digest_d;
            wc_q     <= wc_d;
            ld_q     <= ld_d;
            ld1_q    <= ld_q;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
            pad_q    <= pad_d;
`ifdef SPECK_LOADER_LEN_EN
            len_q    <= len_d;
`endif
        end
    end

    assign bus.msg_ready    = ready;
    assign bus.core_x       = x_q;
    assign bus.core_y       = y_q;
    assign bus.core_k       = KEY;
    assign bus.core_h       = h_q;
    assign bus.core_ld      = ld_q;
    assign bus.core_ld1     = ld1_q;
    assign bus.core_cnt_rst = ld_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = dv_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_speck_msg_loader.sv
// Self-checking bench for speck_msg_loader: random messages against a block-list reference model,
// with a stand-in core computing hout = x^y^h exactly CORE_LAT cycles after core_ld.
module tb_speck_msg_loader;
    import speck_msg_loader_pkg::*;

    localparam int unsigned       LAT   = 14;
    localparam logic [WORD_W-1:0] IV_T  = 64'h0123_4567_89AB_CDEF;
    localparam logic [WORD_W-1:0] KEY_T = 64'h0F0E_0D0C_0B0A_0908;
    localparam logic [WORD_W-1:0] PAD_T = 64'h8000_0000_0000_0000;
    localparam int unsigned       TMO   = 400;

    typedef struct packed { logic [63:0] x; logic [63:0] y; logic [63:0] h; } blk_t;
    typedef logic [63:0] wq_t[$];
    typedef blk_t        bq_t[$];

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    speck_msg_loader_if bus ();

    speck_msg_loader #(
        .CORE_LAT (LAT),
        .IV       (IV_T),
        .KEY      (KEY_T),
        .PAD_WORD (PAD_T)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    // Stand-in core: result valid only in the single cycle CORE_LAT after core_ld, noise otherwise.
    logic [63:0] cm_val;
    int unsigned cm_n;
    bit          cm_act = 1'b0;
    always @(negedge clk) begin
        if (bus.core_ld === 1'b1) begin
            cm_act = 1'b1;
            cm_n   = 0;
            cm_val = bus.core_x ^ bus.core_y ^ bus.core_h;
        end else if (cm_act) begin
            cm_n++;
        end
        bus.core_hout = (cm_act && cm_n == LAT) ? cm_val : {$urandom, $urandom};
    end

    blk_t        obs_q[$];
    int unsigned ld_cyc[$], ld1_cyc[$], rs_cyc[$];
    int unsigned cyc = 0;
    int unsigned dv_cnt = 0;
    always @(negedge clk) begin
        blk_t b;
        cyc++;
        if (bus.core_ld === 1'b1) begin
            b.x = bus.core_x;
            b.y = bus.core_y;
            b.h = bus.core_h;
            obs_q.push_back(b);
            ld_cyc.push_back(cyc);
        end
        if (bus.core_ld1 === 1'b1)     ld1_cyc.push_back(cyc);
        if (bus.core_cnt_rst === 1'b1) rs_cyc.push_back(cyc);
        if (bus.digest_valid === 1'b1) dv_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word stream = message, PAD, zero fill, optional length; cut into pairs and fold the chain.
    function automatic void build_ref(input wq_t w, output bq_t exp, output logic [63:0] dig);
        wq_t         s;
        logic [63:0] h;
        blk_t        b;
        s = w;
        s.push_back(PAD_T);
`ifdef SPECK_LOADER_LEN_EN
        if (s.size() % 2 == 0) s.push_back(64'h0);
        s.push_back(64'(w.size()) * 64);
`else
        if (s.size() % 2 == 1) s.push_back(64'h0);
`endif
        exp.delete();
        h = IV_T;
        for (int i = 0; i < s.size(); i += 2) begin
            b.x = s[i];
            b.y = s[i+1];
            b.h = h;
            exp.push_back(b);
            h = s[i] ^ s[i+1] ^ h;
        end
        dig = h;
    endfunction

    function automatic wq_t rand_words(input int unsigned n);
        wq_t w;
        for (int unsigned i = 0; i < n; i++) w.push_back({$urandom, $urandom});
        return w;
    endfunction

    task automatic check_reset_values();
        check("rst_core_x", bus.core_x, 64'h0);
        check("rst_core_y", bus.core_y, 64'h0);
        check("rst_core_h", bus.core_h, IV_T);
        check("rst_core_k", bus.core_k, KEY_T);
        check("rst_digest", bus.digest, 64'h0);
        check("rst_ctrl", {59'h0, bus.core_ld, bus.core_ld1, bus.core_cnt_rst, bus.digest_valid, bus.busy}, 64'h0);
        check("rst_msg_ready", 64'(bus.msg_ready), 64'd1);
    endtask

    task automatic run_msg(input wq_t w, input bit hold, input bit abort);
        bq_t         exp;
        logic [63:0] dig, x0, y0;
        int unsigned b0, l0, d0, waited;
        bit          stable;
        build_ref(w, exp, dig);
        b0 = obs_q.size();
        l0 = ld1_cyc.size();
        d0 = dv_cnt;
        for (int i = 0; i < w.size(); i++) begin
            if (!(hold && i == 2)) repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.msg_data  = w[i];
            bus.msg_valid = 1'b1;
            bus.msg_last  = (i == w.size() - 1);
            waited = 0;
            stable = 1'b1;
            x0     = bus.core_x;
            y0     = bus.core_y;
            while (bus.msg_ready !== 1'b1 && waited < TMO) begin
                @(negedge clk);
                if (bus.core_x !== x0 || bus.core_y !== y0) stable = 1'b0;
                waited++;
            end
            check("accept_timeout", 64'(waited < TMO), 64'd1);
            if (hold && i == 2) begin
                check("ready_low_while_core_runs", 64'(waited >= LAT), 64'd1);
                check("xy_stable_while_stalled", 64'(stable), 64'd1);
            end
            @(posedge clk);
            @(negedge clk);
            bus.msg_valid = 1'b0;
            bus.msg_last  = 1'b0;
            if (i == 0) check("busy_after_first_word", 64'(bus.busy), 64'd1);
        end

        if (abort) begin
            waited = 0;
            while (obs_q.size() - b0 < 2 && waited < TMO) begin
                @(negedge clk);
                waited++;
            end
            check("abort_reach_block2", 64'(waited < TMO), 64'd1);
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_reset_values();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (3 * LAT) @(negedge clk);
            check("no_digest_after_abort", 64'(dv_cnt - d0), 64'd0);
            check("ready_after_abort", 64'(bus.msg_ready), 64'd1);
            return;
        end

        waited = 0;
        while (bus.digest_valid !== 1'b1 && waited < TMO) begin
            @(negedge clk);
            waited++;
        end
        check("digest_timeout", 64'(waited < TMO), 64'd1);
        check("digest", bus.digest, dig);
        check("busy_low_with_digest", 64'(bus.busy), 64'd0);
        check("core_h_back_to_iv", bus.core_h, IV_T);
        @(negedge clk);
        check("digest_valid_one_cycle", 64'(bus.digest_valid), 64'd0);
        check("digest_valid_count", 64'(dv_cnt - d0), 64'd1);
        check("block_count", 64'(obs_q.size() - b0), 64'(exp.size()));
        check("ld1_count", 64'(ld1_cyc.size() - l0), 64'(exp.size()));
        for (int k = 0; k < exp.size() && b0 + k < obs_q.size(); k++) begin
            check($sformatf("blk%0d_x", k), obs_q[b0+k].x, exp[k].x);
            check($sformatf("blk%0d_y", k), obs_q[b0+k].y, exp[k].y);
            check($sformatf("blk%0d_h", k), obs_q[b0+k].h, exp[k].h);
            check($sformatf("blk%0d_cnt_rst", k), 64'(rs_cyc[b0+k]), 64'(ld_cyc[b0+k]));
            if (l0 + k < ld1_cyc.size())
                check($sformatf("blk%0d_ld1_after_ld", k), 64'(ld1_cyc[l0+k]), 64'(ld_cyc[b0+k] + 1));
            if (k > 0)
                check($sformatf("blk%0d_ld_spacing", k), 64'(ld_cyc[b0+k] - ld_cyc[b0+k-1] > LAT), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1);
    end

    initial begin
        wq_t w;
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.msg_data  = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        w = '{64'h1};
        run_msg(w, 1'b0, 1'b0);
        w = '{64'hA, 64'hB};
        run_msg(w, 1'b0, 1'b0);
        w = rand_words(3);
        run_msg(w, 1'b1, 1'b0);
        w = rand_words(4);
        run_msg(w, 1'b0, 1'b0);
        w = rand_words(5);
        run_msg(w, 1'b1, 1'b0);
        w = rand_words(3);
        run_msg(w, 1'b0, 1'b1);
        w = rand_words(2);
        run_msg(w, 1'b0, 1'b0);
        w = rand_words(1);
        run_msg(w, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
